// File: rtl/pcpi_dispatch_pkg.sv
// Shared definitions for the PCPI M-extension dispatcher: FSM state encoding,
// RV32M decode constants, the request payload bundle and the default timeout.
package pcpi_dispatch_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 64;
  // funct3 at or above this value routes to the divider slave
  localparam int unsigned FUNCT3_DIV_SPLIT = 4;

  localparam logic [6:0] M_OPCODE = 7'b0110011;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Request latched on acceptance and presented to the selected slave
  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } pcpi_req_t;

endpackage

// File: rtl/pcpi_dispatch_m_decode.sv
// Combinational RV32M detector and slave selector.
// Ports: insn_i (instruction word), is_m_c_o (instruction is an M-extension op),
//        sel_div_c_o (1 = divider slave, 0 = multiplier slave).
module pcpi_m_decode
  import pcpi_dispatch_pkg::*;
(
  input  logic [XLEN-1:0] insn_i,
  output logic            is_m_c_o,
  output logic            sel_div_c_o
);

  assign is_m_c_o    = (insn_i[6:0] == M_OPCODE) && (insn_i[31:25] == M_FUNCT7);
  assign sel_div_c_o = (insn_i[14:12] >= 3'(FUNCT3_DIV_SPLIT));

  // Register and rd fields play no part in the decision
  logic unused_insn_bits;
  assign unused_insn_bits = ^{insn_i[24:15], insn_i[11:7]};

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: accepts RV32M requests from the core, forwards them to a
// multiplier or divider PCPI slave, returns the slave result, and forces a
// zero result with a sticky error flag if the slave does not answer in time.
// Ports: clk/reset (sync, active-high); core side pcpi_valid/insn/rs1/rs2 in,
//        pcpi_wr/rd/wait/ready out; mul_* and div_* slave request outputs and
//        response inputs; timeout_err sticky forced-completion flag.
module pcpi_dispatch
  import pcpi_dispatch_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [XLEN-1:0] pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready,
  output logic            mul_valid,
  output logic [XLEN-1:0] mul_insn,
  output logic [XLEN-1:0] mul_rs1,
  output logic [XLEN-1:0] mul_rs2,
  input  logic            mul_wr,
  input  logic [XLEN-1:0] mul_rd,
  input  logic            mul_wait,
  input  logic            mul_ready,
  output logic            div_valid,
  output logic [XLEN-1:0] div_insn,
  output logic [XLEN-1:0] div_rs1,
  output logic [XLEN-1:0] div_rs2,
  input  logic            div_wr,
  input  logic [XLEN-1:0] div_rd,
  input  logic            div_wait,
  input  logic            div_ready,
  output logic            timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  pcpi_req_t       req_q, req_d;
  logic            sel_div_q, sel_div_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            wait_q, wait_d;
  logic            ready_q, ready_d;
  logic            mul_valid_q, mul_valid_d;
  logic            div_valid_q, div_valid_d;
  logic            terr_q, terr_d;

  logic            dec_is_m_c;
  logic            dec_sel_div_c;
  logic            slv_ready_c;
  logic            slv_wr_c;
  logic [XLEN-1:0] slv_rd_c;

  pcpi_m_decode u_decode (
    .insn_i      (pcpi_insn),
    .is_m_c_o    (dec_is_m_c),
    .sel_div_c_o (dec_sel_div_c)
  );

  // Only the selected slave's response is observed
  assign slv_ready_c = sel_div_q ? div_ready : mul_ready;
  assign slv_wr_c    = sel_div_q ? div_wr    : mul_wr;
  assign slv_rd_c    = sel_div_q ? div_rd    : mul_rd;

  // Slave busy hints carry no information the dispatcher needs
  logic unused_slave_wait;
  assign unused_slave_wait = mul_wait ^ div_wait;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      req_q       <= '0;
      sel_div_q   <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      wait_q      <= 1'b0;
      ready_q     <= 1'b0;
      mul_valid_q <= 1'b0;
      div_valid_q <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
      sel_div_q   <= sel_div_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wait_q      <= wait_d;
      ready_q     <= ready_d;
      mul_valid_q <= mul_valid_d;
      div_valid_q <= div_valid_d;
      terr_q      <= terr_d;
    end
  end

  // Next state; outputs are derived from the state being entered so they
  // appear registered in the same cycle as that state
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    req_d     = req_q;
    sel_div_d = sel_div_q;
    wr_d      = 1'b0;
    rd_d      = '0;
    ready_d   = 1'b0;
    terr_d    = terr_q;

    case (state_q)
      ST_IDLE: begin
        if (pcpi_valid && dec_is_m_c) begin
          req_d     = '{insn: pcpi_insn, rs1: pcpi_rs1, rs2: pcpi_rs2};
          sel_div_d = dec_sel_div_c;
          timer_d   = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A response arriving on the expiry cycle beats the timeout
        if (slv_ready_c) begin
          rd_d    = slv_rd_c;
          wr_d    = slv_wr_c;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          ready_d = 1'b1;
          terr_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    wait_d      = (state_d == ST_BUSY);
    mul_valid_d = wait_d && !sel_div_d;
    div_valid_d = wait_d && sel_div_d;
  end

  assign pcpi_wr     = wr_q;
  assign pcpi_rd     = rd_q;
  assign pcpi_wait   = wait_q;
  assign pcpi_ready  = ready_q;
  assign mul_valid   = mul_valid_q;
  assign mul_insn    = req_q.insn;
  assign mul_rs1     = req_q.rs1;
  assign mul_rs2     = req_q.rs2;
  assign div_valid   = div_valid_q;
  assign div_insn    = req_q.insn;
  assign div_rs1     = req_q.rs1;
  assign div_rs2     = req_q.rs2;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed bench for pcpi_dispatch: MUL/DIVU dispatch, non-M rejection,
// timeout and ready-on-expiry, mid-operation reset and back-to-back requests.
module tb_pcpi_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        mul_valid, mul_wr, mul_wait, mul_ready;
  logic [31:0] mul_insn, mul_rs1, mul_rs2, mul_rd;
  logic        div_valid, div_wr, div_wait, div_ready;
  logic [31:0] div_insn, div_rs1, div_rs2, div_rd;
  logic        timeout_err;

  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_DIVU = 32'h0220D1B3;
  localparam logic [31:0] I_ADD  = 32'h002081B3;

  int checks = 0;
  int failures = 0;
  int mul_v_cnt = 0;
  int div_v_cnt = 0;
  int rdy_cnt = 0;
  int base_m, base_d, base_r, n;

  pcpi_dispatch #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .mul_valid(mul_valid), .mul_insn(mul_insn), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2),
    .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait), .mul_ready(mul_ready),
    .div_valid(div_valid), .div_insn(div_insn), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_valid === 1'b1) mul_v_cnt++;
    if (div_valid === 1'b1) div_v_cnt++;
    if (pcpi_ready === 1'b1) rdy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 32'(pcpi_ready), 32'd0);
    check({tag, "_wait"},  32'(pcpi_wait),  32'd0);
    check({tag, "_wr"},    32'(pcpi_wr),    32'd0);
    check({tag, "_rd"},    pcpi_rd,         32'd0);
    check({tag, "_mulv"},  32'(mul_valid),  32'd0);
    check({tag, "_divv"},  32'(div_valid),  32'd0);
  endtask

  task automatic core_req(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
  endtask

  initial begin
    reset = 1'b1;
    pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    mul_wr = 1'b0; mul_rd = '0; mul_wait = 1'b0; mul_ready = 1'b0;
    div_wr = 1'b0; div_rd = '0; div_wait = 1'b0; div_ready = 1'b0;
    tick(); tick();
    check_quiet("reset");
    check("reset_terr", 32'(timeout_err), 32'd0);
    check("reset_mulinsn", mul_insn, 32'd0);
    check("reset_divrs1", div_rs1, 32'd0);
    reset = 1'b0;
    tick();

    // MUL 7*6, slave answers on the third BUSY cycle
    base_d = div_v_cnt;
    core_req(I_MUL, 32'd7, 32'd6);
    tick();
    check("mul_valid", 32'(mul_valid), 32'd1);
    check("mul_wait", 32'(pcpi_wait), 32'd1);
    check("mul_insn", mul_insn, I_MUL);
    check("mul_rs1", mul_rs1, 32'd7);
    check("mul_rs2", mul_rs2, 32'd6);
    check("mul_busy_ready", 32'(pcpi_ready), 32'd0);
    tick();
    tick();
    check("mul_still_busy", 32'(mul_valid), 32'd1);
    mul_ready = 1'b1; mul_rd = 32'd42; mul_wr = 1'b1;
    tick();
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = '0;
    check("mul_ready", 32'(pcpi_ready), 32'd1);
    check("mul_rd", pcpi_rd, 32'd42);
    check("mul_wr", 32'(pcpi_wr), 32'd1);
    check("mul_resp_wait", 32'(pcpi_wait), 32'd0);
    check("mul_resp_valid", 32'(mul_valid), 32'd0);
    pcpi_valid = 1'b0;
    tick();
    check_quiet("mul_hold");
    tick();
    check_quiet("mul_idle");
    check("mul_insn_held", mul_insn, I_MUL);
    check("mul_no_div", 32'(div_v_cnt - base_d), 32'd0);

    // DIVU 100/7, stray multiplier response must be ignored
    base_m = mul_v_cnt;
    core_req(I_DIVU, 32'd100, 32'd7);
    tick();
    check("div_valid", 32'(div_valid), 32'd1);
    check("div_rs1", div_rs1, 32'd100);
    check("div_rs2", div_rs2, 32'd7);
    div_ready = 1'b1; div_rd = 32'd14; div_wr = 1'b1;
    mul_ready = 1'b1; mul_rd = 32'd99; mul_wr = 1'b1;
    tick();
    div_ready = 1'b0; div_wr = 1'b0; mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = '0;
    check("div_ready", 32'(pcpi_ready), 32'd1);
    check("div_rd", pcpi_rd, 32'd14);
    pcpi_valid = 1'b0;
    tick(); tick();
    check("div_no_mul", 32'(mul_v_cnt - base_m), 32'd0);

    // Non-M request held for 20 cycles is never accepted
    base_m = mul_v_cnt; base_d = div_v_cnt; base_r = rdy_cnt;
    core_req(I_ADD, 32'd1, 32'd2);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("add_wait", 32'(pcpi_wait), 32'd0);
      check("add_ready", 32'(pcpi_ready), 32'd0);
    end
    pcpi_valid = 1'b0;
    tick();
    check("add_slave_valids", 32'((mul_v_cnt - base_m) + (div_v_cnt - base_d)), 32'd0);
    check("add_no_ready", 32'(rdy_cnt - base_r), 32'd0);

    // Slave ready on the expiry cycle wins over the timeout
    core_req(I_MUL, 32'd2, 32'd3);
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("edge_no_ready_yet", 32'(pcpi_ready), 32'd0);
    mul_ready = 1'b1; mul_rd = 32'd6; mul_wr = 1'b1;
    tick();
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = '0;
    check("edge_ready", 32'(pcpi_ready), 32'd1);
    check("edge_rd", pcpi_rd, 32'd6);
    check("edge_wr", 32'(pcpi_wr), 32'd1);
    check("edge_terr", 32'(timeout_err), 32'd0);
    pcpi_valid = 1'b0;
    tick(); tick();

    // Slave never answers: forced completion 65 cycles after acceptance
    mul_rd = 32'hDEADBEEF; mul_wr = 1'b1;
    core_req(I_MUL, 32'd4, 32'd5);
    tick();
    n = 1;
    while (pcpi_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("to_latency", 32'(n), 32'd65);
    check("to_wr", 32'(pcpi_wr), 32'd0);
    check("to_rd", pcpi_rd, 32'd0);
    check("to_terr", 32'(timeout_err), 32'd1);
    pcpi_valid = 1'b0; mul_wr = 1'b0; mul_rd = '0;
    tick(); tick(); tick();
    check("to_terr_sticky", 32'(timeout_err), 32'd1);

    // Reset while BUSY abandons the transaction
    base_r = rdy_cnt;
    core_req(I_MUL, 32'd8, 32'd8);
    tick(); tick();
    check("rst_busy", 32'(pcpi_wait), 32'd1);
    pcpi_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mul_ready = 1'b1; mul_rd = 32'd5; mul_wr = 1'b1;
    check_quiet("rst_out");
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_mulrs1", mul_rs1, 32'd0);
    tick();
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = '0;
    check_quiet("rst_late");
    check("rst_no_ready", 32'(rdy_cnt - base_r), 32'd0);
    core_req(I_MUL, 32'd11, 32'd3);
    tick();
    mul_ready = 1'b1; mul_rd = 32'd33; mul_wr = 1'b1;
    tick();
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = '0;
    check("post_rst_ready", 32'(pcpi_ready), 32'd1);
    check("post_rst_rd", pcpi_rd, 32'd33);
    pcpi_valid = 1'b0;
    tick(); tick();

    // Back-to-back MULs with valid lingering through RESP and HOLD
    base_r = rdy_cnt;
    core_req(I_MUL, 32'd3, 32'd5);
    tick();
    mul_ready = 1'b1; mul_rd = 32'd15; mul_wr = 1'b1;
    tick();
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = '0;
    check("b2b1_ready", 32'(pcpi_ready), 32'd1);
    check("b2b1_rd", pcpi_rd, 32'd15);
    tick();
    check_quiet("b2b_hold");
    core_req(I_MUL, 32'd9, 32'd4);
    tick();
    check_quiet("b2b_idle");
    tick();
    check("b2b2_valid", 32'(mul_valid), 32'd1);
    check("b2b2_rs1", mul_rs1, 32'd9);
    mul_ready = 1'b1; mul_rd = 32'd36; mul_wr = 1'b1;
    tick();
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = '0;
    check("b2b2_ready", 32'(pcpi_ready), 32'd1);
    check("b2b2_rd", pcpi_rd, 32'd36);
    pcpi_valid = 1'b0;
    tick();
    check("b2b2_single", 32'(pcpi_ready), 32'd0);
    tick();
    check("b2b_pulses", 32'(rdy_cnt - base_r), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
